// File: rtl/pc_seq_pkg.sv
// Shared definitions for the instruction-address sequencer: FSM states and
// the default geometry of the program region.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } pc_state_e;

  localparam int unsigned DEF_XLEN     = 64;
  localparam int unsigned DEF_STEP     = 4;
  localparam int unsigned DEF_PC_LIMIT = 'h200;

endpackage

// File: rtl/pc_target_check.sv
// Classifies a candidate fetch address: misaligned to STEP, or at/above the
// exclusive PC_LIMIT. The address is XLEN+1 bits so a carry-out reads as out of range.
module pc_target_check
  import pc_seq_pkg::*;
#(
  parameter int unsigned     XLEN     = DEF_XLEN,
  parameter int unsigned     STEP     = DEF_STEP,
  parameter logic [XLEN-1:0] PC_LIMIT = XLEN'(DEF_PC_LIMIT)
) (
  input  logic [XLEN:0] addr,
  output logic          misaligned,
  output logic          out_of_range
);

  localparam int unsigned AW = $clog2(STEP);

  assign misaligned   = |addr[AW-1:0];
  assign out_of_range = (addr >= {1'b0, PC_LIMIT});

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: steps the fetch address, applies redirects,
// stalls and halts, and reports completion / misaligned-redirect faults.
//
// Handshake: none of the inputs uses valid/ready flow control. redirect_valid
// qualifies redirect_target for exactly the cycle it is high; there is no
// back-pressure, a redirect is consumed on the edge it is sampled (or dropped
// in DONE/FAULT/IDLE where requests are ignored).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     XLEN         = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] PC_LIMIT     = XLEN'(DEF_PC_LIMIT),
  parameter int unsigned     STEP         = DEF_STEP,
  parameter int unsigned     CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic             halt_req,
  input  logic             restart,
  output logic [XLEN-1:0]  pc,
  output logic             pc_valid,
  output logic             done,
  output logic             fault,
  output logic [XLEN-1:0]  fault_addr,
  output logic [CNT_W-1:0] step_count,
  output pc_state_e        dbg_state
);

  localparam logic [XLEN:0] STEP_EXT = (XLEN+1)'(STEP);

  pc_state_e       state, next_state;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] fault_addr_next;
  logic            count_en;
  logic            count_clr;

  logic [XLEN:0]   seq_sum;
  logic            tgt_misaligned, tgt_out_of_range;
  logic            seq_misaligned, seq_out_of_range;

  assign seq_sum = {1'b0, pc} + STEP_EXT;

  pc_target_check #(
    .XLEN     (XLEN),
    .STEP     (STEP),
    .PC_LIMIT (PC_LIMIT)
  ) u_tgt_check (
    .addr         ({1'b0, redirect_target}),
    .misaligned   (tgt_misaligned),
    .out_of_range (tgt_out_of_range)
  );

  pc_target_check #(
    .XLEN     (XLEN),
    .STEP     (STEP),
    .PC_LIMIT (PC_LIMIT)
  ) u_seq_check (
    .addr         (seq_sum),
    .misaligned   (seq_misaligned),
    .out_of_range (seq_out_of_range)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Priority inside RUN: halt, then redirect (which beats stall), then stall,
  // then sequential stepping until the next address leaves the region.
  always_comb begin
    next_state      = state;
    pc_next         = pc;
    fault_addr_next = fault_addr;
    count_en        = 1'b0;
    count_clr       = 1'b0;
    case (state)
      IDLE: begin
        next_state = RUN;
      end
      RUN: begin
        if (halt_req) begin
          next_state = DONE;
        end else if (redirect_valid) begin
          if (tgt_misaligned) begin
            next_state      = FAULT;
            fault_addr_next = redirect_target;
          end else if (tgt_out_of_range) begin
            next_state = DONE;
          end else begin
            pc_next  = redirect_target;
            count_en = 1'b1;
          end
        end else if (stall) begin
          pc_next = pc;
        end else if (!seq_out_of_range && !seq_misaligned) begin
          pc_next  = seq_sum[XLEN-1:0];
          count_en = 1'b1;
        end else begin
          next_state = DONE;
        end
      end
      DONE, FAULT: begin
        if (restart) begin
          next_state = RUN;
          pc_next    = RESET_VECTOR;
          count_clr  = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_VECTOR;
      fault_addr <= '0;
      step_count <= '0;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      pc         <= pc_next;
      fault_addr <= fault_addr_next;
      done       <= (next_state == DONE);
      fault      <= (next_state == FAULT);
      if (count_clr) begin
        step_count <= '0;
      end else if (count_en && (step_count != {CNT_W{1'b1}})) begin
        step_count <= step_count + 1'b1;
      end
    end
  end

  assign pc_valid  = (state == RUN);
  assign dbg_state = state;

endmodule
